// File: rtl/alu_seq_unit.sv
// Sequential ALU: decodes ALUOp/funct, executes one op, shift-add multiply over XLEN cycles.
// Latency: 1 cycle for single-cycle ops and illegal selectors, XLEN+1 cycles for mul.
// Backpressure: accepts only in IDLE; result is held in DONE until ready_i, with no queueing.
module alu_seq_unit #(
   parameter int XLEN    = 32,
   parameter int FUNCT_W = 10
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [1:0]         ALUOp_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [XLEN-1:0]    a_i,
   input  logic [XLEN-1:0]    b_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [XLEN-1:0]    result_o,
   output logic               zero_o,
   output logic               illegal_o,
   output logic [3:0]         ALUCtrl_o,
   output logic               busy_o
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRL = 4'b0111;
   localparam logic [3:0] OP_SRA = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] acc_next;

   logic [6:0]      f7;
   logic [2:0]      f3;
   logic [3:0]      dec_code;
   logic            dec_ill;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;

   assign f7    = 7'(funct_i >> 3);
   assign f3    = funct_i[2:0];
   assign shamt = b_i[SHW-1:0];

   // Translate operation class and {funct7, funct3} into the internal op code.
   always_comb begin
      dec_code = OP_ADD;
      dec_ill  = 1'b0;
      case (ALUOp_i)
         2'b00: dec_code = OP_ADD;
         2'b01: dec_code = OP_SUB;
         2'b10: begin
            case ({f7, f3})
               10'b0000000_000: dec_code = OP_ADD;
               10'b0100000_000: dec_code = OP_SUB;
               10'b0000001_000: dec_code = OP_MUL;
               10'b0000000_111: dec_code = OP_AND;
               10'b0000000_110: dec_code = OP_OR;
               10'b0000000_100: dec_code = OP_XOR;
               10'b0000000_001: dec_code = OP_SLL;
               10'b0000000_101: dec_code = OP_SRL;
               10'b0100000_101: dec_code = OP_SRA;
               default:         dec_ill  = 1'b1;
            endcase
         end
         default: begin
            // I-format: funct7 only matters for the shift encodings
            case (f3)
               3'b000: dec_code = OP_ADD;
               3'b111: dec_code = OP_AND;
               3'b110: dec_code = OP_OR;
               3'b100: dec_code = OP_XOR;
               3'b001: begin
                  if (f7 == 7'b0000000) dec_code = OP_SLL;
                  else                  dec_ill  = 1'b1;
               end
               3'b101: begin
                  if (f7 == 7'b0000000)      dec_code = OP_SRL;
                  else if (f7 == 7'b0100000) dec_code = OP_SRA;
                  else                       dec_ill  = 1'b1;
               end
               default: dec_ill = 1'b1;
            endcase
         end
      endcase
      // unsupported selectors report as add with a zero result
      if (dec_ill) dec_code = OP_ADD;
   end

   // Single-cycle datapath evaluated on the live inputs, captured only at accept.
   always_comb begin
      alu_res = '0;
      case (dec_code)
         OP_AND:  alu_res = a_i & b_i;
         OP_OR:   alu_res = a_i | b_i;
         OP_ADD:  alu_res = a_i + b_i;
         OP_XOR:  alu_res = a_i ^ b_i;
         OP_SLL:  alu_res = a_i << shamt;
         OP_SUB:  alu_res = a_i - b_i;
         OP_SRL:  alu_res = a_i >> shamt;
         OP_SRA:  alu_res = XLEN'($signed(a_i) >>> shamt);
         default: alu_res = '0;
      endcase
      if (dec_ill) alu_res = '0;
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
   end

   // Control FSM plus operand, accumulator and result registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         result_o  <= '0;
         illegal_o <= 1'b0;
         ALUCtrl_o <= 4'b0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (valid_i) begin
                  ALUCtrl_o <= dec_code;
                  illegal_o <= dec_ill;
                  if (dec_code == OP_MUL) begin
                     mcand  <= a_i;
                     mplier <= b_i;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= S_MUL;
                  end else begin
                     result_o <= alu_res;
                     state    <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(XLEN - 1)) begin
                  result_o <= acc_next;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (ready_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready_o = (state == S_IDLE) && !rst_i;
   assign busy_o  = (state == S_MUL);
   assign valid_o = (state == S_DONE);
   assign zero_o  = valid_o && (result_o == '0);

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

   logic        clk_i;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  ALUOp_i;
   logic [9:0]  funct_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        zero_o;
   logic        illegal_o;
   logic [3:0]  ALUCtrl_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  op;
      logic [9:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  c;
      logic        ill;
   } vec_t;

   vec_t vecs [0:17];

   alu_seq_unit #(.XLEN(32), .FUNCT_W(10)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .ALUOp_i   (ALUOp_i),
      .funct_i   (funct_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .result_o  (result_o),
      .zero_o    (zero_o),
      .illegal_o (illegal_o),
      .ALUCtrl_o (ALUCtrl_o),
      .busy_o    (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Present one operation for a single edge, then drop valid_i.
   task automatic do_op(input logic [1:0] op, input logic [9:0] f,
                        input logic [31:0] a, input logic [31:0] b);
      ALUOp_i = op; funct_i = f; a_i = a; b_i = b; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL rst_result: got %h want 0", result_o); end
      checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL rst_zero: got %b want 0", zero_o); end
      checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal_o); end
      checks++; if (ALUCtrl_o !== 4'b0000) begin errors++; $display("FAIL rst_ctrl: got %b want 0000", ALUCtrl_o); end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", ready_o); end
   endtask

   task automatic test_decode();
      vecs[0]  = '{2'b00, 10'h3FF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0010, 1'b0};
      vecs[1]  = '{2'b01, 10'h155, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110, 1'b0};
      vecs[2]  = '{2'b10, 10'h100, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0110, 1'b0};
      vecs[3]  = '{2'b10, 10'h007, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 4'b0000, 1'b0};
      vecs[4]  = '{2'b10, 10'h006, 32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b0001, 1'b0};
      vecs[5]  = '{2'b10, 10'h004, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0100, 1'b0};
      vecs[6]  = '{2'b10, 10'h001, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0101, 1'b0};
      vecs[7]  = '{2'b10, 10'h005, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0111, 1'b0};
      vecs[8]  = '{2'b10, 10'h000, 32'h00000007, 32'h00000009, 32'h00000010, 4'b0010, 1'b0};
      vecs[9]  = '{2'b11, 10'h3FF, 32'h000000FF, 32'h0000000F, 32'h0000000F, 4'b0000, 1'b0};
      vecs[10] = '{2'b11, 10'h004, 32'h00000005, 32'h00000003, 32'h00000006, 4'b0100, 1'b0};
      vecs[11] = '{2'b11, 10'h105, 32'hF0000000, 32'h0000001C, 32'hFFFFFFFF, 4'b1000, 1'b0};
      vecs[12] = '{2'b11, 10'h001, 32'h00000003, 32'h00000004, 32'h00000030, 4'b0101, 1'b0};
      vecs[13] = '{2'b11, 10'h006, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0001, 1'b0};
      vecs[14] = '{2'b11, 10'h009, 32'h00000003, 32'h00000004, 32'h00000000, 4'b0010, 1'b1};
      vecs[15] = '{2'b11, 10'h101, 32'h00000003, 32'h00000004, 32'h00000000, 4'b0010, 1'b1};
      vecs[16] = '{2'b10, 10'h002, 32'h00000011, 32'h00000022, 32'h00000000, 4'b0010, 1'b1};
      vecs[17] = '{2'b11, 10'h002, 32'h00000012, 32'h00000034, 32'h00000000, 4'b0010, 1'b1};
      ready_i = 1'b1;
      for (int i = 0; i < 18; i++) begin
         do_op(vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b);
         checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL dec%0d_valid: got %b want 1", i, valid_o); end
         checks++; if (result_o !== vecs[i].r) begin errors++; $display("FAIL dec%0d_result: got %h want %h", i, result_o, vecs[i].r); end
         checks++; if (ALUCtrl_o !== vecs[i].c) begin errors++; $display("FAIL dec%0d_ctrl: got %b want %b", i, ALUCtrl_o, vecs[i].c); end
         checks++; if (illegal_o !== vecs[i].ill) begin errors++; $display("FAIL dec%0d_illegal: got %b want %b", i, illegal_o, vecs[i].ill); end
         checks++; if (zero_o !== (vecs[i].r == 32'h0)) begin errors++; $display("FAIL dec%0d_zero: got %b want %b", i, zero_o, (vecs[i].r == 32'h0)); end
         @(posedge clk_i); #1;
         checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL dec%0d_ready_back: got %b want 1", i, ready_o); end
      end
   endtask

   task automatic test_mul();
      int n;
      ready_i = 1'b1;
      do_op(2'b10, 10'h008, 32'h00010001, 32'h00010001);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mul_ready_busy: got %b want 0", ready_o); end
      n = 0;
      while (busy_o === 1'b1 && n < 40) begin
         n++;
         @(posedge clk_i); #1;
      end
      checks++; if (n !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 32", n); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mul_valid: got %b want 1", valid_o); end
      checks++; if (result_o !== 32'h00020001) begin errors++; $display("FAIL mul_result: got %h want 00020001", result_o); end
      checks++; if (ALUCtrl_o !== 4'b0011) begin errors++; $display("FAIL mul_ctrl: got %b want 0011", ALUCtrl_o); end
      checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL mul_illegal: got %b want 0", illegal_o); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_mul_ignore_inputs();
      int n;
      ready_i = 1'b1;
      do_op(2'b10, 10'h008, 32'h00000003, 32'h00000007);
      ALUOp_i = 2'b00; funct_i = 10'h000; a_i = 32'd100; b_i = 32'd100; valid_i = 1'b1;
      n = 0;
      while (valid_o !== 1'b1 && n < 40) begin
         n++;
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mulign_timeout: valid %b after %0d cycles want 1", valid_o, n); end
      checks++; if (result_o !== 32'd21) begin errors++; $display("FAIL mulign_result: got %h want 00000015", result_o); end
      checks++; if (ALUCtrl_o !== 4'b0011) begin errors++; $display("FAIL mulign_ctrl: got %b want 0011", ALUCtrl_o); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_hold();
      ready_i = 1'b0;
      do_op(2'b10, 10'h105, 32'h80000000, 32'h00000004);
      ALUOp_i = 2'b00; a_i = 32'h1; b_i = 32'h1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL hold%0d_valid: got %b want 1", i, valid_o); end
         checks++; if (result_o !== 32'hF8000000) begin errors++; $display("FAIL hold%0d_result: got %h want f8000000", i, result_o); end
         checks++; if (ALUCtrl_o !== 4'b1000) begin errors++; $display("FAIL hold%0d_ctrl: got %b want 1000", i, ALUCtrl_o); end
         checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL hold%0d_ready: got %b want 0", i, ready_o); end
         @(posedge clk_i); #1;
      end
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b want 0", valid_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", ready_o); end
   endtask

   task automatic test_reset_during_mul();
      logic saw_valid;
      ready_i = 1'b1;
      do_op(2'b10, 10'h008, 32'h00001234, 32'h00005678);
      repeat (9) begin @(posedge clk_i); #1; end
      rst_i = 1'b1;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmul_busy: got %b want 0", busy_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmul_valid: got %b want 0", valid_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rstmul_ready_in_reset: got %b want 0", ready_o); end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmul_ready_after: got %b want 1", ready_o); end
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (valid_o === 1'b1) saw_valid = 1'b1;
         @(posedge clk_i); #1;
      end
      checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rstmul_no_valid: got %b want 0", saw_valid); end
      do_op(2'b00, 10'h000, 32'd3, 32'd4);
      checks++; if (result_o !== 32'd7) begin errors++; $display("FAIL rstmul_add: got %h want 00000007", result_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rstmul_add_valid: got %b want 1", valid_o); end
      @(posedge clk_i); #1;
   endtask

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      ALUOp_i = 2'b00; funct_i = 10'h0; a_i = 32'h0; b_i = 32'h0;
      test_reset();
      test_decode();
      test_mul();
      test_mul_ignore_inputs();
      test_hold();
      test_reset_during_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
